// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle LEGv8 core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a
// ready handshake and a wait timeout. It flags illegal opcodes and counts
// retired instructions.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   Op[10:0]        IR[31:21]; decoded and latched in DECODE
//   Zero            ALU zero flag, used for CBZ/CBNZ in EXEC
//   mem_ready       memory completes the current request this cycle
//   IRWrite..RegWrite  datapath controls (Moore on state/class/Zero/mem_ready)
//   state[2:0]      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERR=5
//   illegal         sticky, undecodable opcode seen
//   mem_timeout     sticky, mem_ready not seen within TIMEOUT cycles
//   instret         retired-instruction counter (wraps)
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IorD,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_R, CL_I, CL_LD, CL_ST, CL_CBZ, CL_CBNZ, CL_B, CL_ILL
  } class_t;

  state_t            r_state;
  class_t            r_class;
  class_t            w_class;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;
  logic              r_illegal;
  logic              r_timeout;
  logic              w_ready;

  // Reset forces the mem_ready=0 view so FETCH never issues IRWrite/PCWrite
  // while reset is held.
  assign w_ready = mem_ready & ~reset;

  always_comb begin
    w_class = CL_ILL;
    casez (Op)
      11'b1?0_0101_1000: w_class = CL_R;
      11'b10?_0101_0000: w_class = CL_R;
      11'b1?0_1000_100?: w_class = CL_I;
      11'b111_1100_0010: w_class = CL_LD;
      11'b111_1100_0000: w_class = CL_ST;
      11'b101_1010_0???: w_class = CL_CBZ;
      11'b101_1010_1???: w_class = CL_CBNZ;
      11'b000_101?_????: w_class = CL_B;
      default:           w_class = CL_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_class   <= CL_NONE;
      r_wait    <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_wait <= '0;
      case (r_state)
        ST_FETCH: begin
          if (w_ready) begin
            r_state <= ST_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            r_state   <= ST_ERR;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          r_class <= w_class;
          if (w_class == CL_ILL) begin
            r_state   <= ST_ERR;
            r_illegal <= 1'b1;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_class)
            CL_R, CL_I:    r_state <= ST_WB;
            CL_LD, CL_ST:  r_state <= ST_MEM;
            CL_CBZ, CL_CBNZ, CL_B: begin
              r_state   <= ST_FETCH;
              r_instret <= r_instret + CNT_W'(1);
            end
            default:       r_state <= ST_ERR;
          endcase
        end
        ST_MEM: begin
          if (w_ready) begin
            if (r_class == CL_LD) begin
              r_state <= ST_WB;
            end else begin
              r_state   <= ST_FETCH;
              r_instret <= r_instret + CNT_W'(1);
            end
          end else if (r_wait == WAIT_LAST) begin
            r_state   <= ST_ERR;
            r_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_WB: begin
          r_state   <= ST_FETCH;
          r_instret <= r_instret + CNT_W'(1);
        end
        ST_ERR:  r_state <= ST_ERR;
        default: r_state <= ST_ERR;
      endcase
    end
  end

  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 2'b00;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    case (r_state)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (w_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      ST_EXEC: begin
        case (r_class)
          CL_R: ALUOp = 2'b10;
          CL_I: begin
            ALUSrc = 1'b1;
            ALUOp  = 2'b11;
          end
          CL_LD: ALUSrc = 1'b1;
          CL_ST: begin
            ALUSrc  = 1'b1;
            Reg2Loc = 1'b1;
          end
          CL_CBZ, CL_CBNZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 1'b1;
            PCWrite = (r_class == CL_CBZ) ? Zero : ~Zero;
          end
          CL_B: begin
            PCSrc   = 1'b1;
            PCWrite = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        IorD   = 1'b1;
        ALUSrc = 1'b1;
        if (r_class == CL_LD) MemRead = 1'b1;
        if (r_class == CL_ST) begin
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (r_class == CL_LD);
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign illegal     = r_illegal;
  assign mem_timeout = r_timeout;
  assign instret     = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Each expected cycle (inputs plus expected state/controls/counters) is
// queued as stimulus is planned, then replayed and compared cycle by cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        Zero;
  logic        mem_ready;
  logic        IRWrite, PCWrite, PCSrc, IorD, Reg2Loc, ALUSrc;
  logic [1:0]  ALUOp;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic [2:0]  state;
  logic        illegal, mem_timeout;
  logic [31:0] instret;
  logic [11:0] ctl_now;

  multicycle_ctrl #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .state(state), .illegal(illegal), .mem_timeout(mem_timeout),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // {IRWrite,PCWrite,PCSrc,IorD}_{Reg2Loc,ALUSrc,ALUOp}_{MemRead,MemWrite,MemtoReg,RegWrite}
  assign ctl_now = {IRWrite, PCWrite, PCSrc, IorD, Reg2Loc, ALUSrc, ALUOp,
                    MemRead, MemWrite, MemtoReg, RegWrite};

  localparam logic [11:0] C_F0    = 12'b0000_0000_1000;
  localparam logic [11:0] C_F1    = 12'b1100_0000_1000;
  localparam logic [11:0] C_ZERO  = 12'b0000_0000_0000;
  localparam logic [11:0] C_EXR   = 12'b0000_0010_0000;
  localparam logic [11:0] C_EXI   = 12'b0000_0111_0000;
  localparam logic [11:0] C_EXLD  = 12'b0000_0100_0000;
  localparam logic [11:0] C_EXST  = 12'b0000_1100_0000;
  localparam logic [11:0] C_EXCB0 = 12'b0010_1001_0000;
  localparam logic [11:0] C_EXCB1 = 12'b0110_1001_0000;
  localparam logic [11:0] C_EXB   = 12'b0110_0000_0000;
  localparam logic [11:0] C_MEMLD = 12'b0001_0100_1000;
  localparam logic [11:0] C_MEMST = 12'b0001_1100_0100;
  localparam logic [11:0] C_WBR   = 12'b0000_0000_0001;
  localparam logic [11:0] C_WBLD  = 12'b0000_0000_0011;

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2,
                         S_M = 3'd3, S_W = 3'd4, S_ERR = 3'd5;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_CBZ = 4,
                 K_CBNZ = 5, K_B = 6;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001001;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_B2   = 11'b00010111111;

  typedef struct {
    logic [10:0] op;
    logic        rdy;
    logic        z;
    logic [2:0]  st;
    logic [11:0] ctl;
    logic [31:0] ir;
    logic        ill;
    logic        to;
  } step_t;

  step_t       q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ir;
  logic        exp_ill;
  logic        exp_to;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [10:0] op, input logic rdy, input logic z,
                      input logic [2:0] st, input logic [11:0] c);
    step_t s;
    s.op = op; s.rdy = rdy; s.z = z; s.st = st; s.ctl = c;
    s.ir = exp_ir; s.ill = exp_ill; s.to = exp_to;
    q.push_back(s);
  endtask

  // Called at posedge+1: drive inputs, compare at negedge, advance one cycle.
  task automatic drain();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      Op = s.op; mem_ready = s.rdy; Zero = s.z;
      @(negedge clk);
      check("state", 32'(state), 32'(s.st));
      check("ctl", 32'(ctl_now), 32'(s.ctl));
      check("instret", instret, s.ir);
      check("illegal", 32'(illegal), 32'(s.ill));
      check("mem_timeout", 32'(mem_timeout), 32'(s.to));
      @(posedge clk); #1;
    end
  endtask

  task automatic instr(input logic [10:0] op, input int kind, input logic z,
                       input int fwait, input int mwait);
    for (int i = 0; i < fwait; i++) push(op, 1'b0, z, S_F, C_F0);
    push(op, 1'b1, z, S_F, C_F1);
    push(op, 1'b1, z, S_D, C_ZERO);
    case (kind)
      K_R: begin push(op, 1'b1, z, S_E, C_EXR); push(op, 1'b1, z, S_W, C_WBR); end
      K_I: begin push(op, 1'b1, z, S_E, C_EXI); push(op, 1'b1, z, S_W, C_WBR); end
      K_LD: begin
        push(op, 1'b1, z, S_E, C_EXLD);
        for (int i = 0; i < mwait; i++) push(op, 1'b0, z, S_M, C_MEMLD);
        push(op, 1'b1, z, S_M, C_MEMLD);
        push(op, 1'b1, z, S_W, C_WBLD);
      end
      K_ST: begin
        push(op, 1'b1, z, S_E, C_EXST);
        for (int i = 0; i < mwait; i++) push(op, 1'b0, z, S_M, C_MEMST);
        push(op, 1'b1, z, S_M, C_MEMST);
      end
      K_CBZ:  push(op, 1'b1, z, S_E, z ? C_EXCB1 : C_EXCB0);
      K_CBNZ: push(op, 1'b1, z, S_E, z ? C_EXCB0 : C_EXCB1);
      default: push(op, 1'b1, z, S_E, C_EXB);
    endcase
    exp_ir = exp_ir + 32'd1;
  endtask

  // Reset values are visible without any clock edge; mem_ready=1 must not
  // leak into IRWrite/PCWrite while reset is held.
  task automatic check_reset();
    check("rst_state", 32'(state), 32'(S_F));
    check("rst_ctl", 32'(ctl_now), 32'(C_F0));
    check("rst_instret", instret, 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
  endtask

  task automatic reset_mid();
    mem_ready = 1'b1;
    #1 reset = 1'b1;
    #1 check_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ir = '0; exp_ill = 1'b0; exp_to = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Op = '0; Zero = 1'b0; mem_ready = 1'b1;
    exp_ir = '0; exp_ill = 1'b0; exp_to = 1'b0;
    #2 check_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // R-type, immediates, loads/stores, branches, all with ready memory
    instr(OP_ADD,  K_R,    1'b0, 0, 0);
    instr(OP_SUB,  K_R,    1'b0, 0, 0);
    instr(OP_AND,  K_R,    1'b0, 0, 0);
    instr(OP_ORR,  K_R,    1'b0, 0, 0);
    instr(OP_ADDI, K_I,    1'b0, 0, 0);
    instr(OP_SUBI, K_I,    1'b0, 0, 0);
    instr(OP_LDUR, K_LD,   1'b0, 0, 0);
    instr(OP_STUR, K_ST,   1'b0, 0, 0);
    instr(OP_LDUR, K_LD,   1'b0, 2, 3);
    instr(OP_STUR, K_ST,   1'b0, 0, 2);
    instr(OP_CBZ,  K_CBZ,  1'b1, 0, 0);
    instr(OP_CBNZ, K_CBNZ, 1'b1, 0, 0);
    instr(OP_CBZ,  K_CBZ,  1'b0, 0, 0);
    instr(OP_CBNZ, K_CBNZ, 1'b0, 0, 0);
    instr(OP_B,    K_B,    1'b0, 0, 0);
    instr(OP_B2,   K_B,    1'b1, 0, 0);
    // fetch timeout: 15 not-ready cycles then ERR, which ignores mem_ready
    for (int i = 0; i < 15; i++) push(OP_ADD, 1'b0, 1'b0, S_F, C_F0);
    exp_to = 1'b1;
    for (int i = 0; i < 3; i++) push(OP_ADD, 1'b1, 1'b1, S_ERR, C_ZERO);
    drain();
    reset_mid();

    // ready on the 15th wait cycle completes normally
    instr(OP_ADD, K_R, 1'b0, 14, 0);
    // illegal opcode goes to ERR, flag sticky
    push(11'b0, 1'b1, 1'b0, S_F, C_F1);
    push(11'b0, 1'b1, 1'b0, S_D, C_ZERO);
    exp_ill = 1'b1;
    for (int i = 0; i < 20; i++) push(11'b0, 1'b1, 1'b0, S_ERR, C_ZERO);
    drain();
    reset_mid();

    // reset while a store is held in MEM
    push(OP_STUR, 1'b1, 1'b0, S_F, C_F1);
    push(OP_STUR, 1'b1, 1'b0, S_D, C_ZERO);
    push(OP_STUR, 1'b1, 1'b0, S_E, C_EXST);
    push(OP_STUR, 1'b0, 1'b0, S_M, C_MEMST);
    push(OP_STUR, 1'b0, 1'b0, S_M, C_MEMST);
    drain();
    mem_ready = 1'b0;
    #1 check("mem_hold_write", 32'(MemWrite), 32'd1);
    reset_mid();
    instr(OP_ADD, K_R, 1'b0, 0, 0);
    push(OP_ADD, 1'b0, 1'b0, S_F, C_F0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control unit for the multicycle LEGv8 core. It replaces the single-cycle opcode decoder with a registered FSM that sequences FETCH/DECODE/EXEC/MEM/WB over a shared memory port. The memory port uses a ready handshake with a timeout. The unit adds ADDI/SUBI, CBNZ and B, flags illegal opcodes, and keeps a retired-instruction counter.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready in any memory state before entering ERR (must be >= 1)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
Op  in  11  IR[31:21]; stable from the DECODE cycle until the next IRWrite
Zero  in  1  ALU zero flag, sampled in EXEC
mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle
IRWrite  out  1  load IR from memory read data
PCWrite  out  1  load PC
PCSrc  out  1  0 = PC+4, 1 = branch target
IorD  out  1  0 = memory address from PC, 1 = from ALU result
Reg2Loc  out  1  read register 2 select, same meaning as in the single-cycle decoder
ALUSrc  out  1  0 = register, 1 = sign-extended immediate
ALUOp  out  2  00 add, 01 pass/compare, 10 funct decode, 11 immediate add/sub (Op[9] selects sub)
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  writeback source is memory
RegWrite  out  1  register file write
state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5
illegal  out  1  sticky; set on undecodable opcode
mem_timeout  out  1  sticky; set on mem_ready timeout
instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous): state=FETCH, class=NONE, wait counter=0, instret=0, illegal=0, mem_timeout=0.
- All control outputs are Moore outputs of (state, class, Zero, mem_ready). Any output not listed for a state is 0.
- While reset is asserted, outputs are the FETCH outputs with mem_ready=0: MemRead=1, IorD=0, everything else 0.
- Opcode classes are decoded from Op with casez and registered in DECODE:
  - R: 1?0_0101_1000 (ADD/SUB), 10?_0101_0000 (AND/ORR)
  - I: 1?0_1000_100? (ADDI/SUBI)
  - LD: 111_1100_0010
  - ST: 111_1100_0000
  - CBZ: 101_1010_0???
  - CBNZ: 101_1010_1???
  - B: 000_101?_????
  - Anything else: ILL.
- FETCH: MemRead=1, IorD=0. If mem_ready: IRWrite=1, PCWrite=1, PCSrc=0, go to DECODE. Otherwise stay.
- DECODE: latch class, ALUSrc=0. ILL goes to ERR and sets illegal. All other classes go to EXEC.
- EXEC, by class:
  - R: ALUOp=10, then WB.
  - I: ALUSrc=1, ALUOp=11, then WB.
  - LD/ST: ALUSrc=1, ALUOp=00, then MEM. ST also drives Reg2Loc=1.
  - CBZ/CBNZ: Reg2Loc=1, ALUOp=01, PCSrc=1, PCWrite=Zero for CBZ or !Zero for CBNZ, then FETCH, instret+1.
  - B: PCSrc=1, PCWrite=1, then FETCH, instret+1.
- MEM: IorD=1, ALUSrc=1, ALUOp=00. LD drives MemRead=1; ST drives MemWrite=1 and Reg2Loc=1. Hold until mem_ready. Then LD goes to WB; ST goes to FETCH with instret+1.
- WB: RegWrite=1, MemtoReg=(class==LD). Go to FETCH, instret+1.
- Wait counter:
  - Cleared on entry to FETCH and MEM.
  - Increments each cycle mem_ready=0 in those states.
  - If the count reaches TIMEOUT with mem_ready still 0: go to ERR, set mem_timeout. No IRWrite/PCWrite is issued.
  - mem_ready on the same cycle the count reaches TIMEOUT wins: normal completion.
- ERR: terminal. All control outputs 0. Only reset exits.
- instret increments at most once per instruction and wraps modulo 2^CNT_W.
- Reset mid-operation aborts immediately. Partial MEM state is discarded; no write enables are held.

Test Plan:
- ADD (Op=10001011000), mem_ready=1 every cycle → state sequence 0,1,2,4,0. RegWrite high only in WB. instret 0→1 after 4 cycles.
- LDUR then STUR with mem_ready=1 → LDUR 5 cycles (MemtoReg=1 in WB), STUR 4 cycles (MemWrite=1, IorD=1 in MEM, RegWrite never 1). instret=2.
- CBZ with Zero=1, then CBNZ with Zero=1 → CBZ: PCWrite=1, PCSrc=1 in EXEC. CBNZ: PCWrite=0. Each takes 3 cycles. B (Op=00010100000) → PCWrite=1 in EXEC.
- FETCH with mem_ready held low, TIMEOUT=15 → ERR after 15 wait cycles, mem_timeout=1, outputs 0. Repeat with mem_ready=1 on the 15th cycle → normal DECODE.
- Op=00000000000 → ERR after DECODE, illegal=1 sticky over 20 cycles. Reset → state=0, illegal=0, instret=0 asynchronously (mid-cycle).
- Reset asserted in MEM of a STUR → MemWrite drops without a clock edge. After release, FETCH with MemRead=1.
